countdown_timer: RTL and testbench

- Down-counting minutes:seconds timer; the complement of the free-running up-counting minutes counter in the stopwatch datapath.
- Loads a preset of up to 99:59, counts down once per second while running, and holds at 00:00.
- Raises a one-cycle done pulse on expiry for the display and alarm logic.
- Contains its own clock-cycle prescaler and a four-state control FSM.

---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with a built-in one-second prescaler and a four-state control FSM.
// Define AUTO_RELOAD_EN to restart from the last loaded preset on expiry instead of holding at 00:00.
module countdown_timer #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int MAX_MIN       = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [6:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   input  logic       stop,
   output logic [6:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       expired,
   output logic       done
);

   localparam int PW = $clog2(TICKS_PER_SEC);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   state_t        state_q, state_d;
   logic [6:0]    curMin_q, curMin_d;
   logic [5:0]    curSec_q, curSec_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic          done_q, done_d;
`ifdef AUTO_RELOAD_EN
   logic [6:0]    presetMin_q, presetMin_d;
   logic [5:0]    presetSec_q, presetSec_d;
`endif

   logic [6:0] clampMin, decMin;
   logic [5:0] clampSec, decSec;
   logic       tick, curZero, decZero;

   // Out-of-range presets saturate to the largest legal value.
   assign clampMin = (load_min > 7'(MAX_MIN)) ? 7'(MAX_MIN) : load_min;
   assign clampSec = (load_sec > 6'd59) ? 6'd59 : load_sec;

   // Borrow from minutes only when seconds is already zero; 00:00 never reaches RUN.
   assign decMin  = (curSec_q != 6'd0) ? curMin_q : curMin_q - 7'd1;
   assign decSec  = (curSec_q != 6'd0) ? curSec_q - 6'd1 : 6'd59;
   assign decZero = (decMin == 7'd0) && (decSec == 6'd0);
   assign curZero = (curMin_q == 7'd0) && (curSec_q == 6'd0);
   assign tick    = (prescale_q == PW'(TICKS_PER_SEC - 1));

   always_comb begin
      state_d    = state_q;
      curMin_d   = curMin_q;
      curSec_d   = curSec_q;
      prescale_d = prescale_q;
      done_d     = 1'b0;
`ifdef AUTO_RELOAD_EN
      presetMin_d = presetMin_q;
      presetSec_d = presetSec_q;
`endif
      if (load) begin
         curMin_d   = clampMin;
         curSec_d   = clampSec;
         prescale_d = '0;
         state_d    = IDLE;
`ifdef AUTO_RELOAD_EN
         presetMin_d = clampMin;
         presetSec_d = clampSec;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (!stop && start && !curZero) begin
                  state_d    = RUN;
                  prescale_d = '0;
               end
            end
            RUN: begin
               // A stop landing on a tick cycle freezes the prescaler at its terminal count.
               if (stop) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  prescale_d = '0;
                  curMin_d   = decMin;
                  curSec_d   = decSec;
                  if (decZero) begin
                     done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                     curMin_d = presetMin_q;
                     curSec_d = presetSec_q;
`else
                     state_d  = EXPIRED;
`endif
                  end
               end else begin
                  prescale_d = prescale_q + 1'b1;
               end
            end
            PAUSE: begin
               if (!stop && start) begin
                  state_d = RUN;
               end
            end
            EXPIRED: begin
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         curMin_q   <= '0;
         curSec_q   <= '0;
         prescale_q <= '0;
         done_q     <= 1'b0;
`ifdef AUTO_RELOAD_EN
         presetMin_q <= '0;
         presetSec_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         curMin_q   <= curMin_d;
         curSec_q   <= curSec_d;
         prescale_q <= prescale_d;
         done_q     <= done_d;
`ifdef AUTO_RELOAD_EN
         presetMin_q <= presetMin_d;
         presetSec_q <= presetSec_d;
`endif
      end
   end

   assign minutes = curMin_q;
   assign seconds = curSec_q;
   assign running = (state_q == RUN);
   assign expired = (state_q == EXPIRED);
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer with a four-cycle second; covers AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

   localparam int TICKS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [6:0] loadMin = '0;
   logic [5:0] loadSec = '0;
   logic [6:0] minutes;
   logic [5:0] seconds;
   logic       running;
   logic       expired;
   logic       done;

   typedef struct {
      string       tag;
      logic [15:0] value;
   } exp_t;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;

   countdown_timer #(.TICKS_PER_SEC(TICKS), .MAX_MIN(99)) dut (
      .clk(clk), .rst(rst), .load(load), .load_min(loadMin), .load_sec(loadSec),
      .start(start), .stop(stop), .minutes(minutes), .seconds(seconds),
      .running(running), .expired(expired), .done(done)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge, so sampling and driving stay clear of it.
   task automatic applyStimulus(input logic iRst, input logic iLoad, input logic [6:0] iMin,
                                input logic [5:0] iSec, input logic iStart, input logic iStop);
      rst     = iRst;
      load    = iLoad;
      loadMin = iMin;
      loadSec = iSec;
      start   = iStart;
      stop    = iStop;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      exp_t        e;
      logic [15:0] obs;
      obs = {minutes, seconds, running, expired, done};
      checks++;
      if (sbQ.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard-empty: observed %0d:%0d with no expectation", minutes, seconds);
      end else begin
         e = sbQ.pop_front();
         assert (obs === e.value) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d:%0d run=%b exp=%b done=%b, expected %0d:%0d run=%b exp=%b done=%b",
                   e.tag, obs[15:9], obs[8:3], obs[2], obs[1], obs[0],
                   e.value[15:9], e.value[8:3], e.value[2], e.value[1], e.value[0]);
         end
      end
   endtask

   task automatic step(input string tag, input logic iRst, input logic iLoad, input logic [6:0] iMin,
                       input logic [5:0] iSec, input logic iStart, input logic iStop,
                       input logic [6:0] eMin, input logic [5:0] eSec,
                       input logic eRun, input logic eExp, input logic eDone);
      exp_t x;
      x.tag   = tag;
      x.value = {eMin, eSec, eRun, eExp, eDone};
      sbQ.push_back(x);
      applyStimulus(iRst, iLoad, iMin, iSec, iStart, iStop);
      checkOutput();
   endtask

   task automatic idle(input string tag, input logic [6:0] eMin, input logic [5:0] eSec,
                       input logic eRun, input logic eExp, input logic eDone);
      step(tag, 1'b0, 1'b0, 7'd0, 6'd0, 1'b0, 1'b0, eMin, eSec, eRun, eExp, eDone);
   endtask

   initial begin
      int total;

      // Basic countdown from 00:03
      step("rst0", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("load3", 0, 1, 7'd0, 6'd3, 0, 0, 7'd0, 6'd3, 0, 0, 0);
      step("start3", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd3, 1, 0, 0);
      for (int k = 1; k < 12; k++)
         idle($sformatf("basic%0d", k), 7'd0, 6'(3 - k / TICKS), 1, 0, 0);
`ifdef AUTO_RELOAD_EN
      idle("reload3", 7'd0, 6'd3, 1, 0, 1);
      idle("reload3Hold", 7'd0, 6'd3, 1, 0, 0);
      step("stopAfterReload", 0, 0, 7'd0, 6'd0, 0, 1, 7'd0, 6'd3, 0, 0, 0);
`else
      idle("expire", 7'd0, 6'd0, 0, 1, 1);
      idle("expireHold", 7'd0, 6'd0, 0, 1, 0);
      step("startInExpired", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd0, 0, 1, 0);
      step("stopInExpired", 0, 0, 7'd0, 6'd0, 0, 1, 7'd0, 6'd0, 0, 1, 0);
      idle("expireHold2", 7'd0, 6'd0, 0, 1, 0);
`endif

      // Borrow and clamping
      step("rst1", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("load200", 0, 1, 7'd2, 6'd0, 0, 0, 7'd2, 6'd0, 0, 0, 0);
      step("start200", 0, 0, 7'd0, 6'd0, 1, 0, 7'd2, 6'd0, 1, 0, 0);
      for (int k = 1; k < TICKS; k++)
         idle($sformatf("borrowWait%0d", k), 7'd2, 6'd0, 1, 0, 0);
      idle("borrow", 7'd1, 6'd59, 1, 0, 0);
      step("clamp120_63", 0, 1, 7'd120, 6'd63, 0, 0, 7'd99, 6'd59, 0, 0, 0);
      step("load130", 0, 1, 7'd1, 6'd30, 0, 0, 7'd1, 6'd30, 0, 0, 0);
      step("clamp100_60", 0, 1, 7'd100, 6'd60, 0, 0, 7'd99, 6'd59, 0, 0, 0);

      // Pause and resume, including a stop that lands on a tick cycle
      step("rst2", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("load5", 0, 1, 7'd0, 6'd5, 0, 0, 7'd0, 6'd5, 0, 0, 0);
      step("start5", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd5, 1, 0, 0);
      for (int k = 1; k <= 6; k++)
         idle($sformatf("pauseRun%0d", k), 7'd0, 6'(5 - k / TICKS), 1, 0, 0);
      step("stopAt4", 0, 0, 7'd0, 6'd0, 0, 1, 7'd0, 6'd4, 0, 0, 0);
      for (int k = 0; k < 20; k++)
         step($sformatf("pauseHold%0d", k), 0, 0, 7'd0, 6'd0, 0, logic'(k % 3 == 0),
              7'd0, 6'd4, 0, 0, 0);
      step("resume", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd4, 1, 0, 0);
      idle("resume1", 7'd0, 6'd4, 1, 0, 0);
      idle("resume2", 7'd0, 6'd3, 1, 0, 0);
      for (int k = 1; k < TICKS; k++)
         idle($sformatf("toTick%0d", k), 7'd0, 6'd3, 1, 0, 0);
      step("stopOnTick", 0, 0, 7'd0, 6'd0, 0, 1, 7'd0, 6'd3, 0, 0, 0);
      step("stopStartPause", 0, 0, 7'd0, 6'd0, 1, 1, 7'd0, 6'd3, 0, 0, 0);
      step("resumeOnTick", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd3, 1, 0, 0);
      idle("heldTick", 7'd0, 6'd2, 1, 0, 0);
      step("stopStartRun", 0, 0, 7'd0, 6'd0, 1, 1, 7'd0, 6'd2, 0, 0, 0);

      // Ignored controls in IDLE
      step("rst3", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("startAtZero", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd0, 0, 0, 0);
      step("loadWithStart", 0, 1, 7'd0, 6'd7, 1, 0, 7'd0, 6'd7, 0, 0, 0);
      for (int k = 0; k < 5; k++)
         idle($sformatf("idleHold%0d", k), 7'd0, 6'd7, 0, 0, 0);

      // Reset in the middle of a count
      step("load1000", 0, 1, 7'd10, 6'd0, 0, 0, 7'd10, 6'd0, 0, 0, 0);
      step("start1000", 0, 0, 7'd0, 6'd0, 1, 0, 7'd10, 6'd0, 1, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         total = 600 - k / TICKS;
         idle($sformatf("midRun%0d", k), 7'(total / 60), 6'(total % 60), 1, 0, 0);
      end
      step("midReset", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("startAfterReset", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd0, 0, 0, 0);
      idle("afterResetHold", 7'd0, 6'd0, 0, 0, 0);

`ifdef AUTO_RELOAD_EN
      // Automatic reload from the preset on every expiry
      step("rst4", 1, 0, 7'd0, 6'd0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
      step("load2", 0, 1, 7'd0, 6'd2, 0, 0, 7'd0, 6'd2, 0, 0, 0);
      step("start2", 0, 0, 7'd0, 6'd0, 1, 0, 7'd0, 6'd2, 1, 0, 0);
      for (int k = 1; k <= 17; k++)
         idle($sformatf("auto%0d", k), 7'd0, ((k % 8) < 4) ? 6'd2 : 6'd1, 1, 0,
              logic'(k % 8 == 0));
      step("autoStop", 0, 0, 7'd0, 6'd0, 0, 1, 7'd0, 6'd2, 0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
